avalon_frame_reader: RTL and testbench
======================================

AVALON_FRAME_READER -- requirements
Module: avalon_frame_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 27, meaning Avalon word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning Avalon data width; pixel = bits [23:0].
REQ-003 SHALL have parameter FRAME_WORDS, default 2073600 (1920*1080), meaning words read per frame.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16 (power of two, >=4), meaning pixel FIFO entries.
REQ-005 SHALL have ports: iCLK in 1 sole clock; iRST_n in 1 reset, asynchronous, active-low.
REQ-006 SHALL have ports: local_init_done in 1 LPDDR2 calibrated; start in 1 frame-read request pulse.
REQ-007 SHALL have ports: avl_waitrequest_n in 1; avl_readdata in DATA_W; avl_readdatavalid in 1.
REQ-008 SHALL have ports: avl_address out ADDR_W; avl_read out 1; avl_burstbegin out 1 (equal to avl_read).
REQ-009 SHALL have ports: pix_data out 24; pix_valid out 1; pix_ready in 1; pix_sof out 1; pix_eof out 1.
REQ-010 SHALL have ports: busy out 1 (state not IDLE/DONE); frame_done out 1 (one-cycle pulse); r_state out 2.

Function
REQ-011 SHALL implement states IDLE=0, READ=1, DRAIN=2, DONE=3, encoded on r_state.
REQ-012 IDLE->READ when start && local_init_done, sampled in the same cycle; start otherwise ignored, including while busy.
REQ-013 On entering READ, avl_address SHALL be 0, the word counter 0 and the outstanding counter 0.
REQ-014 In READ, avl_read SHALL assert only when fifo_count + outstanding < FIFO_DEPTH (credit rule; never overflow the FIFO).
REQ-015 A read SHALL be accepted on a cycle with avl_read=1 and avl_waitrequest_n=1; avl_read and avl_address SHALL stay stable while avl_waitrequest_n=0.
REQ-016 On each accept, avl_address SHALL increment by 1 and outstanding SHALL increment; on each avl_readdatavalid, outstanding SHALL decrement; simultaneous events SHALL leave outstanding unchanged.
REQ-017 The accept of address FRAME_WORDS-1 SHALL move READ->DRAIN, with avl_read deasserted the following cycle.
REQ-018 Each avl_readdatavalid beat SHALL push avl_readdata[23:0] into the FIFO in the same cycle; data order SHALL match address order.
REQ-019 The FIFO SHALL be show-ahead: pix_valid=!empty, pix_data=head entry; pop on pix_valid && pix_ready; push and pop in one cycle on a full FIFO SHALL be legal.
REQ-020 pix_sof SHALL be high with the word from address 0; pix_eof SHALL be high with the word from address FRAME_WORDS-1; both qualified by pix_valid.
REQ-021 DRAIN->DONE when outstanding==0 and FIFO empty; frame_done SHALL pulse high for exactly the first cycle in DONE.
REQ-022 Without the loop option, DONE SHALL persist until reset; latency from the final pop to frame_done SHALL be 1 cycle.
REQ-023 avl_readdatavalid beats arriving in IDLE or DONE SHALL be discarded.
REQ-024 All counters SHALL be sized to FRAME_WORDS and FIFO_DEPTH with no wrap before terminal count.

Reset
REQ-025 On iRST_n low, asynchronously: r_state=IDLE, avl_read=0, avl_address=0, pix_valid=0, pix_sof=0, pix_eof=0, busy=0, frame_done=0, FIFO empty, outstanding=0.
REQ-026 Reset mid-frame SHALL abandon the frame; no pixel of the abandoned frame SHALL appear after reset release.

Configuration
REQ-027 Macro FRAME_READER_LOOP_EN defined: DONE SHALL return to READ on the next cycle, address reset to 0, frame_done still pulsing once per frame; start is needed only for the first frame.
REQ-028 Macro FRAME_READER_LOOP_EN undefined: behaviour per REQ-022; no loop logic is synthesised.

Verification
REQ-029 local_init_done=0, start pulse -> r_state stays 0, avl_read never asserts.
REQ-030 FRAME_WORDS=8, zero-wait memory with 2-cycle read latency, pix_ready=1 -> pix_data 0..7 in order, sof with word 0, eof with word 7, one frame_done pulse.
REQ-031 pix_ready=0 throughout, FIFO_DEPTH=16 -> exactly 16 reads accepted, avl_read then held 0; outstanding+fifo_count never exceeds 16.
REQ-032 avl_waitrequest_n toggled randomly -> avl_address/avl_read stable while stalled; no address skipped or repeated.
REQ-033 iRST_n pulsed low after 3 of 8 pixels popped -> all outputs at reset values; a new start yields a clean frame from address 0 with sof.
REQ-034 FRAME_READER_LOOP_EN defined, FRAME_WORDS=4 -> pixel sequence 0,1,2,3,0,1,2,3 with frame_done once per frame.

Source files
------------

// File: rtl/avalon_frame_reader.sv
// ============================================================================
// avalon_frame_reader
// ----------------------------------------------------------------------------
// Reads one video frame (FRAME_WORDS consecutive words starting at word
// address 0) from an LPDDR2 Avalon-MM read port. The low 24 bits of each
// returned word are streamed out as a pixel through a small show-ahead FIFO
// with valid/ready handshake, tagged with start/end-of-frame markers.
//
// Read issue is credit based: a read is only requested while the number of
// reads in flight plus the words already buffered is below FIFO_DEPTH, so
// the FIFO can never overflow regardless of the pixel consumer.
//
// Optional feature (compile-time macro):
//   FRAME_READER_LOOP_EN  - when defined, the reader restarts the frame from
//                           address 0 immediately after each frame completes
//                           (continuous scan-out). When undefined, the reader
//                           stops in DONE until reset.
//
// Parameters:
//   ADDR_W       Avalon word-address width
//   DATA_W       Avalon data width (pixel = bits [23:0], DATA_W >= 24)
//   FRAME_WORDS  words read per frame
//   FIFO_DEPTH   pixel FIFO entries (power of two, >= 4)
//
// Ports:
//   iCLK               sole clock
//   iRST_n             asynchronous active-low reset
//   local_init_done    memory controller calibration complete
//   start              frame-read request pulse (honoured only in IDLE)
//   avl_waitrequest_n  Avalon slave ready (read accepted when high)
//   avl_readdata       Avalon read data
//   avl_readdatavalid  Avalon read data strobe
//   avl_address        Avalon word address
//   avl_read           Avalon read request
//   avl_burstbegin     equal to avl_read (single-word bursts)
//   pix_data           head-of-FIFO pixel
//   pix_valid          FIFO not empty
//   pix_ready          consumer accepts the pixel this cycle
//   pix_sof            pixel is word 0 of the frame
//   pix_eof            pixel is the last word of the frame
//   busy               reader in READ or DRAIN
//   frame_done         one-cycle pulse on entry to DONE
//   r_state            FSM state: 0 IDLE, 1 READ, 2 DRAIN, 3 DONE
// ============================================================================
module avalon_frame_reader #(
   parameter int unsigned ADDR_W      = 27,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned FRAME_WORDS = 2073600,
   parameter int unsigned FIFO_DEPTH  = 16
) (
   input  logic              iCLK,
   input  logic              iRST_n,
   input  logic              local_init_done,
   input  logic              start,
   input  logic              avl_waitrequest_n,
   input  logic [DATA_W-1:0] avl_readdata,
   input  logic              avl_readdatavalid,
   output logic [ADDR_W-1:0] avl_address,
   output logic              avl_read,
   output logic              avl_burstbegin,
   output logic [23:0]       pix_data,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic              pix_sof,
   output logic              pix_eof,
   output logic              busy,
   output logic              frame_done,
   output logic [1:0]        r_state
);

   // Counter widths hold their terminal values without wrapping.
   localparam int unsigned WC_W  = $clog2(FRAME_WORDS + 1);
   localparam int unsigned FC_W  = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned SUM_W = FC_W + 1;

   localparam logic [WC_W-1:0]  LAST_WORD  = WC_W'(FRAME_WORDS - 1);
   localparam logic [FC_W-1:0]  FIFO_FULL  = FC_W'(FIFO_DEPTH);
   localparam logic [SUM_W-1:0] CREDIT_MAX = SUM_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t            state;

   logic [WC_W-1:0]   word_cnt;     // reads accepted this frame
   logic [WC_W-1:0]   rx_cnt;       // beats received this frame
   logic [FC_W-1:0]   outstanding;  // reads accepted, data not yet returned
   logic [FC_W-1:0]   fifo_count;

   logic [FC_W-1:0]   out_next;
   logic [FC_W-1:0]   fifo_next;
   logic [SUM_W-1:0]  credit_sum;
   logic              credit_ok;

   logic              active;
   logic              accept;
   logic              push;
   logic              pop;
   logic              dec;
   logic              sof_tag;
   logic              eof_tag;

   // FIFO entry: {eof, sof, pixel}
   logic [25:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   // -------------------------------------------------------------------------
   // Handshake decode and next-cycle occupancy
   // -------------------------------------------------------------------------
   always_comb begin
      active    = (state == READ) || (state == DRAIN);
      accept    = (state == READ) && avl_read && avl_waitrequest_n;
      pop       = pix_valid && pix_ready;
      // Beats outside READ/DRAIN belong to an abandoned frame and are dropped.
      push      = active && avl_readdatavalid && ((fifo_count != FIFO_FULL) || pop);
      dec       = push && (outstanding != '0);
      out_next  = outstanding + FC_W'(accept) - FC_W'(dec);
      fifo_next = fifo_count + FC_W'(push) - FC_W'(pop);
      // Credit is judged on next-cycle occupancy, so the registered read
      // request it produces is already correct on the cycle it is presented.
      credit_sum = {1'b0, fifo_next} + {1'b0, out_next};
      credit_ok  = credit_sum < CREDIT_MAX;
      sof_tag    = (rx_cnt == '0);
      eof_tag    = (rx_cnt == LAST_WORD);
   end

   // -------------------------------------------------------------------------
   // Show-ahead pixel FIFO
   // -------------------------------------------------------------------------
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         fifo_count <= fifo_next;
      end
   end

   always_ff @(posedge iCLK) begin
      if (push) fifo_mem[wr_ptr] <= {eof_tag, sof_tag, avl_readdata[23:0]};
   end

   always_comb begin
      pix_valid = (fifo_count != '0);
      pix_data  = fifo_mem[rd_ptr][23:0];
      pix_sof   = pix_valid && fifo_mem[rd_ptr][24];
      pix_eof   = pix_valid && fifo_mem[rd_ptr][25];
   end

   // -------------------------------------------------------------------------
   // Frame FSM with registered Avalon request and status outputs
   // -------------------------------------------------------------------------
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state       <= IDLE;
         avl_read    <= 1'b0;
         avl_address <= '0;
         word_cnt    <= '0;
         rx_cnt      <= '0;
         outstanding <= '0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (push) rx_cnt <= rx_cnt + WC_W'(1);

         case (state)
            IDLE: begin
               if (start && local_init_done) begin
                  state       <= READ;
                  busy        <= 1'b1;
                  avl_read    <= 1'b1;   // FIFO is empty here, credit is full
                  avl_address <= '0;
                  word_cnt    <= '0;
                  rx_cnt      <= '0;
                  outstanding <= '0;
               end
            end

            READ: begin
               outstanding <= out_next;
               if (accept) begin
                  avl_address <= avl_address + ADDR_W'(1);
                  word_cnt    <= word_cnt + WC_W'(1);
               end
               if (accept && (word_cnt == LAST_WORD)) begin
                  state    <= DRAIN;
                  avl_read <= 1'b0;
               end else if (avl_read && !avl_waitrequest_n) begin
                  avl_read <= 1'b1;      // hold request while the slave stalls
               end else begin
                  avl_read <= credit_ok;
               end
            end

            DRAIN: begin
               outstanding <= out_next;
               if ((out_next == '0) && (fifo_next == '0)) begin
                  state      <= DONE;
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
               end
            end

            DONE: begin
`ifdef FRAME_READER_LOOP_EN
               state       <= READ;
               busy        <= 1'b1;
               avl_read    <= 1'b1;
               avl_address <= '0;
               word_cnt    <= '0;
               rx_cnt      <= '0;
               outstanding <= '0;
`endif
            end
         endcase
      end
   end

   assign avl_burstbegin = avl_read;
   assign r_state        = state;

   // Only the pixel field of the Avalon word is consumed.
   generate
      if (DATA_W > 24) begin : g_upper
         logic unused_upper;
         assign unused_upper = &{1'b0, avl_readdata[DATA_W-1:24]};
      end
   endgenerate

endmodule

// File: tb/tb_avalon_frame_reader.sv
`timescale 1ns/1ps
// ============================================================================
// tb_avalon_frame_reader
// ----------------------------------------------------------------------------
// Directed bench. Memory model: 2-cycle read latency, data word = {8'hEE,
// address[23:0]}, so pixel i of a frame is expected to equal i.
// Build with FRAME_READER_LOOP_EN defined to run the looping-frame test.
// ============================================================================
module tb_avalon_frame_reader;

`ifdef FRAME_READER_LOOP_EN
   localparam int FW = 4;
`else
   localparam int FW = 8;
`endif
   localparam int DEPTH = 4;
   localparam int AW    = 27;
   localparam int LOGN  = 64;

   logic          clk = 1'b0;
   logic          resetb = 1'b0;
   logic          init_done = 1'b0;
   logic          start = 1'b0;
   logic          wr_n = 1'b1;
   logic [31:0]   rdata;
   logic          rdv;
   logic [AW-1:0] avl_address;
   logic          avl_read;
   logic          avl_burstbegin;
   logic [23:0]   pix_data;
   logic          pix_valid;
   logic          pix_ready = 1'b0;
   logic          pix_sof;
   logic          pix_eof;
   logic          busy;
   logic          frame_done;
   logic [1:0]    r_state;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   avalon_frame_reader #(
      .ADDR_W      (AW),
      .DATA_W      (32),
      .FRAME_WORDS (FW),
      .FIFO_DEPTH  (DEPTH)
   ) u_dut (
      .iCLK              (clk),
      .iRST_n            (resetb),
      .local_init_done   (init_done),
      .start             (start),
      .avl_waitrequest_n (wr_n),
      .avl_readdata      (rdata),
      .avl_readdatavalid (rdv),
      .avl_address       (avl_address),
      .avl_read          (avl_read),
      .avl_burstbegin    (avl_burstbegin),
      .pix_data          (pix_data),
      .pix_valid         (pix_valid),
      .pix_ready         (pix_ready),
      .pix_sof           (pix_sof),
      .pix_eof           (pix_eof),
      .busy              (busy),
      .frame_done        (frame_done),
      .r_state           (r_state)
   );

   // ---------------- memory model: fixed 2-cycle latency --------------------
   logic          v1 = 1'b0, v2 = 1'b0;
   logic [AW-1:0] a1 = '0, a2 = '0;
   always @(posedge clk) begin
      v1 <= avl_read && wr_n;
      a1 <= avl_address;
      v2 <= v1;
      a2 <= a1;
   end
   assign rdv   = v2;
   assign rdata = {8'hEE, a2[23:0]};

   // ---------------- optional random stalls / back-pressure -----------------
   logic rand_wr = 1'b0;
   logic rand_rdy = 1'b0;
   always @(posedge clk) begin
      #1;
      wr_n = rand_wr ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rand_rdy) pix_ready = 1'($urandom_range(0, 1));
   end

   // ---------------- monitor (samples mid-cycle) ----------------------------
   logic [AW-1:0] acc_log [LOGN];
   logic [23:0]   pix_log [LOGN];
   logic          sof_log [LOGN];
   logic          eof_log [LOGN];
   int            acc_n, pop_n, fd_n, stall_err, lat_err, max_inflight;
   logic          read_seen;
   logic          prev_stall = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   logic          eof_pop_prev = 1'b0;

   always @(negedge clk) begin
      if (!resetb) begin
         prev_stall   = 1'b0;
         eof_pop_prev = 1'b0;
      end else begin
         if (avl_read) read_seen = 1'b1;
         if (prev_stall && (!avl_read || avl_address != prev_addr)) stall_err++;
         prev_stall = avl_read && !wr_n;
         prev_addr  = avl_address;
         if (eof_pop_prev && !frame_done) lat_err++;
         eof_pop_prev = pix_valid && pix_ready && pix_eof;
         if (frame_done) fd_n++;
         if (avl_read && wr_n) begin
            if (acc_n < LOGN) acc_log[acc_n] = avl_address;
            acc_n++;
         end
         if (pix_valid && pix_ready) begin
            if (pop_n < LOGN) begin
               pix_log[pop_n] = pix_data;
               sof_log[pop_n] = pix_sof;
               eof_log[pop_n] = pix_eof;
            end
            pop_n++;
         end
         if (acc_n - pop_n > max_inflight) max_inflight = acc_n - pop_n;
      end
   end

   // ---------------- helpers ------------------------------------------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_logs();
      acc_n = 0; pop_n = 0; fd_n = 0;
      stall_err = 0; lat_err = 0; max_inflight = 0;
      read_seen = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic do_reset(input int cycles);
      resetb = 1'b0;
      step(cycles);
      resetb = 1'b1;
      step(2);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_state"},  32'(r_state),     32'd0);
      check({tag, "_read"},   32'(avl_read),    32'd0);
      check({tag, "_addr"},   32'(avl_address), 32'd0);
      check({tag, "_valid"},  32'(pix_valid),   32'd0);
      check({tag, "_sof"},    32'(pix_sof),     32'd0);
      check({tag, "_eof"},    32'(pix_eof),     32'd0);
      check({tag, "_busy"},   32'(busy),        32'd0);
      check({tag, "_fdone"},  32'(frame_done),  32'd0);
   endtask

   task automatic wait_frames(input string tag, input int frames, input int budget);
      int k;
      k = 0;
      while (fd_n < frames && k < budget) begin
         step(1);
         k++;
      end
      check({tag, "_done_seen"}, 32'(fd_n >= frames), 32'd1);
   endtask

   // Checks the first npix popped pixels against the i mod FW pattern.
   task automatic check_pixels(input string tag, input int npix);
      logic [31:0] sof_m, eof_m, sof_x, eof_x;
      sof_m = '0; eof_m = '0; sof_x = '0; eof_x = '0;
      check({tag, "_pop_cnt"}, 32'(pop_n >= npix), 32'd1);
      for (int i = 0; i < npix; i++) begin
         check($sformatf("%s_pix%0d", tag, i), 32'(pix_log[i]), 32'(i % FW));
         sof_m[i] = sof_log[i];
         eof_m[i] = eof_log[i];
         sof_x[i] = (i % FW == 0);
         eof_x[i] = (i % FW == FW - 1);
      end
      check({tag, "_sof_mask"}, sof_m, sof_x);
      check({tag, "_eof_mask"}, eof_m, eof_x);
      check({tag, "_done_lat"}, 32'(lat_err), 32'd0);
   endtask

   // ---------------- watchdog -----------------------------------------------
   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1);
   end

   // ---------------- directed sequence --------------------------------------
   initial begin
      clear_logs();
      step(3);
      check_reset_outputs("rst");
      resetb = 1'b1;
      step(2);

      // start without calibration is ignored
      init_done = 1'b0;
      pulse_start();
      step(10);
      check("nocal_state", 32'(r_state), 32'd0);
      check("nocal_read_seen", 32'(read_seen), 32'd0);
      init_done = 1'b1;

`ifdef FRAME_READER_LOOP_EN
      // continuous frames: 0,1,2,3,0,1,2,3 with one frame_done per frame
      clear_logs();
      pix_ready = 1'b1;
      pulse_start();
      wait_frames("loop", 2, 200);
      check_pixels("loop", 2 * FW);
      check("loop_fd_cnt", 32'(fd_n), 32'd2);
      check("loop_busy", 32'(busy), 32'd1);
      check("loop_credit", 32'(max_inflight <= DEPTH), 32'd1);
`else
      // basic frame, zero-wait memory, consumer always ready
      clear_logs();
      pix_ready = 1'b1;
      pulse_start();
      check("t2_busy", 32'(busy), 32'd1);
      check("t2_state_read", 32'(r_state), 32'd1);
      wait_frames("t2", 1, 200);
      check_pixels("t2", FW);
      check("t2_acc_cnt", 32'(acc_n), 32'(FW));
      check("t2_credit", 32'(max_inflight <= DEPTH), 32'd1);
      step(10);
      check("t2_done_hold", 32'(r_state), 32'd3);
      check("t2_fd_once", 32'(fd_n), 32'd1);
      check("t2_idle_busy", 32'(busy), 32'd0);
      check("t2_no_read", 32'(avl_read), 32'd0);

      // consumer stalled: exactly DEPTH reads, then request held low
      do_reset(2);
      clear_logs();
      pix_ready = 1'b0;
      pulse_start();
      step(30);
      check("t3_acc_cnt", 32'(acc_n), 32'(DEPTH));
      check("t3_read_low", 32'(avl_read), 32'd0);
      check("t3_max_inflight", 32'(max_inflight), 32'(DEPTH));
      check("t3_head_valid", 32'(pix_valid), 32'd1);
      check("t3_head_data", 32'(pix_data), 32'd0);
      check("t3_head_sof", 32'(pix_sof), 32'd1);
      pix_ready = 1'b1;
      wait_frames("t3", 1, 200);
      check_pixels("t3", FW);

      // random slave stalls and random back-pressure; start mid-frame ignored
      do_reset(2);
      clear_logs();
      rand_wr  = 1'b1;
      rand_rdy = 1'b1;
      pulse_start();
      step(3);
      pulse_start();
      wait_frames("t4", 1, 1000);
      rand_wr  = 1'b0;
      rand_rdy = 1'b0;
      step(1);
      pix_ready = 1'b1;
      check("t4_stall_err", 32'(stall_err), 32'd0);
      check("t4_acc_cnt", 32'(acc_n), 32'(FW));
      for (int i = 0; i < FW; i++)
         check($sformatf("t4_addr%0d", i), 32'(acc_log[i]), 32'(i));
      check_pixels("t4", FW);
      check("t4_credit", 32'(max_inflight <= DEPTH), 32'd1);

      // reset after 3 pixels popped, then a clean frame
      do_reset(2);
      clear_logs();
      pix_ready = 1'b1;
      pulse_start();
      begin
         int k;
         k = 0;
         while (pop_n < 3 && k < 100) begin
            step(1);
            k++;
         end
      end
      check("t5_three_popped", 32'(pop_n), 32'd3);
      resetb = 1'b0;
      #1;
      check_reset_outputs("t5rst");
      step(3);
      resetb = 1'b1;
      clear_logs();
      step(10);
      check("t5_no_stale_pop", 32'(pop_n), 32'd0);
      check("t5_idle", 32'(r_state), 32'd0);
      pulse_start();
      wait_frames("t5", 1, 200);
      check_pixels("t5", FW);
      check("t5_acc_first", 32'(acc_log[0]), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
